// File: rtl/rpn_pkg.sv
// Shared definitions for the infix->postfix converter and the postfix evaluator:
// opcodes, error codes and evaluator FSM encoding.
package rpn_pkg;

  localparam int unsigned OPC_W = 3;
  localparam int unsigned ERR_W = 3;

  localparam logic [OPC_W-1:0] OP_ADD = 3'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 3'd1;
  localparam logic [OPC_W-1:0] OP_MUL = 3'd2;
  localparam logic [OPC_W-1:0] OP_EOE = 3'd4;

  localparam logic [ERR_W-1:0] ERR_NONE      = 3'd0;
  localparam logic [ERR_W-1:0] ERR_UNDERFLOW = 3'd1;
  localparam logic [ERR_W-1:0] ERR_OVERFLOW  = 3'd2;
  localparam logic [ERR_W-1:0] ERR_BAD_OP    = 3'd3;
  localparam logic [ERR_W-1:0] ERR_EOE_DEPTH = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACK,
    S_POP_B,
    S_POP_A,
    S_EXEC,
    S_PUSH,
    S_DRAIN,
    S_DRAIN_ACK,
    S_RESULT
  } rpn_state_t;

  function automatic logic is_arith(input logic [OPC_W-1:0] opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_MUL);
  endfunction

endpackage

// File: rtl/rpn_operand_stack.sv
// Operand stack: register array with push/pop/clear, combinational top-of-stack view.
module rpn_operand_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             push_dat,
  output logic [WIDTH-1:0]             top_c,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Entry storage needs no reset: it is only visible through a non-zero depth.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[AW'(depth)] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
    end else if (clear) begin
      depth <= '0;
    end else if (push) begin
      depth <= depth + DW'(1);
    end else if (pop) begin
      depth <= depth - DW'(1);
    end
  end

  always_comb begin
    top_c = '0;
    if (depth != '0) begin
      top_c = mem[AW'(depth - DW'(1))];
    end
  end

  push_pop_exclusive : assert property (@(posedge clk) disable iff (rst) !(push && pop));

endmodule

// File: rtl/rpn_evaluator.sv
// Postfix token evaluator: consumes operand/operator tokens, evaluates on an
// operand stack and presents one result (or first error code) per expression.
module rpn_evaluator
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_stb,
  input  logic [WIDTH-1:0] tok_dat,
  input  logic             tok_is_op,
  output logic             tok_ack,
  output logic             res_stb,
  output logic [WIDTH-1:0] res_dat,
  output logic             res_err,
  input  logic             res_ack
);

  localparam int unsigned DW = $clog2(DEPTH + 1);

  rpn_state_t       state_q, state_d;
  logic [WIDTH-1:0] tok_q;
  logic             is_op_q;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [ERR_W-1:0] err_q, err_d;

  logic             latch, a_ld, b_ld, r_ld, err_ld;
  logic             push, pop, clear;
  logic [WIDTH-1:0] push_dat, top_c, alu_c;
  logic [DW-1:0]    depth;
  logic [OPC_W-1:0] opc;
  logic             tok_ack_d, res_stb_d, res_err_d;
  logic [WIDTH-1:0] res_dat_d;

  rpn_operand_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .push_dat (push_dat),
    .top_c    (top_c),
    .depth    (depth)
  );

  assign opc = tok_q[OPC_W-1:0];

  // ALU: a is the deeper operand, b the former top; results wrap silently.
  always_comb begin
    alu_c = '0;
    unique case (opc)
      OP_ADD:  alu_c = a_q + b_q;
      OP_SUB:  alu_c = a_q - b_q;
      OP_MUL:  alu_c = a_q * b_q;
      default: alu_c = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    r_ld      = 1'b0;
    err_ld    = 1'b0;
    err_d     = err_q;
    push      = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    push_dat  = tok_q;
    tok_ack_d = 1'b0;
    res_stb_d = res_stb;
    res_dat_d = res_dat;
    res_err_d = res_err;

    unique case (state_q)
      S_IDLE: begin
        if (tok_stb) begin
          latch     = 1'b1;
          tok_ack_d = 1'b1;
          state_d   = S_ACK;
        end
      end

      S_ACK: begin
        if (!is_op_q) begin
          if (depth == DW'(DEPTH)) begin
            err_ld  = 1'b1;
            err_d   = ERR_OVERFLOW;
            state_d = S_DRAIN;
          end else begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (is_arith(opc)) begin
          state_d = S_POP_B;
        end else if (opc == OP_EOE) begin
          state_d   = S_RESULT;
          res_stb_d = 1'b1;
          if (depth == DW'(1)) begin
            pop       = 1'b1;
            res_dat_d = top_c;
            res_err_d = 1'b0;
          end else begin
            res_dat_d = WIDTH'(ERR_EOE_DEPTH);
            res_err_d = 1'b1;
          end
        end else begin
          err_ld  = 1'b1;
          err_d   = ERR_BAD_OP;
          state_d = S_DRAIN;
        end
      end

      S_POP_B: begin
        if (depth < DW'(2)) begin
          err_ld  = 1'b1;
          err_d   = ERR_UNDERFLOW;
          state_d = S_DRAIN;
        end else begin
          b_ld    = 1'b1;
          pop     = 1'b1;
          state_d = S_POP_A;
        end
      end

      S_POP_A: begin
        a_ld    = 1'b1;
        pop     = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        r_ld    = 1'b1;
        state_d = S_PUSH;
      end

      S_PUSH: begin
        push     = 1'b1;
        push_dat = r_q;
        state_d  = S_IDLE;
      end

      // Error recovery: swallow the rest of the expression up to its EOE.
      S_DRAIN: begin
        if (tok_stb) begin
          latch     = 1'b1;
          tok_ack_d = 1'b1;
          state_d   = S_DRAIN_ACK;
        end
      end

      S_DRAIN_ACK: begin
        if (is_op_q && (opc == OP_EOE)) begin
          state_d   = S_RESULT;
          res_stb_d = 1'b1;
          res_dat_d = WIDTH'(err_q);
          res_err_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_RESULT: begin
        if (res_ack) begin
          res_stb_d = 1'b0;
          res_err_d = 1'b0;
          clear     = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tok_q   <= '0;
      is_op_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      err_q   <= ERR_NONE;
      tok_ack <= 1'b0;
      res_stb <= 1'b0;
      res_dat <= '0;
      res_err <= 1'b0;
    end else begin
      state_q <= state_d;
      tok_ack <= tok_ack_d;
      res_stb <= res_stb_d;
      res_dat <= res_dat_d;
      res_err <= res_err_d;
      if (latch) begin
        tok_q   <= tok_dat;
        is_op_q <= tok_is_op;
      end
      if (a_ld) a_q <= top_c;
      if (b_ld) b_q <= top_c;
      if (r_ld) r_q <= alu_c;
      if (err_ld) err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Scoreboard bench for rpn_evaluator: stimulus pushes expected results, a monitor pops and compares.
module tb_rpn_evaluator;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned EW    = WIDTH + 1;
  localparam logic [WIDTH-1:0] ADD = 32'd0;
  localparam logic [WIDTH-1:0] SUB = 32'd1;
  localparam logic [WIDTH-1:0] MUL = 32'd2;
  localparam logic [WIDTH-1:0] EOE = 32'd4;

  logic             clk = 1'b0;
  logic             rst;
  logic             tok_stb;
  logic [WIDTH-1:0] tok_dat;
  logic             tok_is_op;
  logic             tok_ack;
  logic             res_stb;
  logic [WIDTH-1:0] res_dat;
  logic             res_err;
  logic             res_ack;

  int          checks = 0;
  int          errors = 0;
  int          ack_cnt = 0;
  bit          hold = 1'b0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rpn_evaluator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_stb   (tok_stb),
    .tok_dat   (tok_dat),
    .tok_is_op (tok_is_op),
    .tok_ack   (tok_ack),
    .res_stb   (res_stb),
    .res_dat   (res_dat),
    .res_err   (res_err),
    .res_ack   (res_ack)
  );

  always @(posedge clk) if (tok_ack) ack_cnt++;

  task automatic check(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_val(input logic [WIDTH-1:0] v);
    exp_q.push_back({1'b0, v});
  endtask

  task automatic expect_err(input int unsigned code);
    exp_q.push_back({1'b1, WIDTH'(code)});
  endtask

  // Present one token and wait (bounded) for its acknowledge pulse.
  task automatic send(input logic is_op, input logic [WIDTH-1:0] d);
    int n;
    tok_stb   = 1'b1;
    tok_is_op = is_op;
    tok_dat   = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tok_ack && n < 100);
    check("tok_ack", EW'(tok_ack), EW'(1));
    tok_stb = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_stb) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("results_drained", EW'(exp_q.size()), EW'(0));
  endtask

  task automatic wait_res_stb();
    int n;
    n = 0;
    while (!res_stb && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("res_stb_rise", EW'(res_stb), EW'(1));
  endtask

  // Monitor: compare each presented result against the scoreboard, then ack it.
  initial begin
    res_ack = 1'b0;
    forever begin
      @(negedge clk);
      res_ack = 1'b0;
      if (!rst && res_stb && !hold) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none", {res_err, res_dat});
        end else begin
          check("result", {res_err, res_dat}, exp_q.pop_front());
        end
        res_ack = 1'b1;
      end
    end
  end

  initial begin
    int a0;
    rst = 1'b1;
    tok_stb = 1'b0;
    tok_dat = '0;
    tok_is_op = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tok_ack", EW'(tok_ack), EW'(0));
    check("rst_res_stb", EW'(res_stb), EW'(0));
    check("rst_res_dat", EW'(res_dat), EW'(0));
    check("rst_res_err", EW'(res_err), EW'(0));
    rst = 1'b0;
    @(negedge clk);

    // 3 4 ADD EOE, with ack count and EOE latency
    a0 = ack_cnt;
    expect_val(32'd7);
    send(1'b0, 32'd3);
    send(1'b0, 32'd4);
    send(1'b1, ADD);
    send(1'b1, EOE);
    check("eoe_stb_not_yet", EW'(res_stb), EW'(0));
    @(negedge clk);
    check("eoe_stb_2cyc", EW'(res_stb), EW'(1));
    wait_done();
    check("ack_count_t1", EW'(ack_cnt - a0), EW'(4));

    // 10 3 SUB 2 MUL EOE; wraparound add; wrapping multiply
    expect_val(32'd14);
    send(1'b0, 32'd10); send(1'b0, 32'd3); send(1'b1, SUB);
    send(1'b0, 32'd2);  send(1'b1, MUL);   send(1'b1, EOE);
    wait_done();
    expect_val(32'h8000_0000);
    send(1'b0, 32'h7FFF_FFFF); send(1'b0, 32'd1); send(1'b1, ADD); send(1'b1, EOE);
    wait_done();
    expect_val(32'd0);
    send(1'b0, 32'h1_0000); send(1'b0, 32'h1_0000); send(1'b1, MUL); send(1'b1, EOE);
    wait_done();
    expect_val(32'hFFFF_FFFD);
    send(1'b0, 32'd2); send(1'b0, 32'd5); send(1'b1, SUB); send(1'b1, EOE);
    wait_done();

    // Underflow: all tokens acked, error 1; then a clean expression
    a0 = ack_cnt;
    expect_err(1);
    send(1'b0, 32'd5); send(1'b1, ADD); send(1'b0, 32'd7); send(1'b1, EOE);
    wait_done();
    check("ack_count_t3", EW'(ack_cnt - a0), EW'(4));
    expect_val(32'd4);
    send(1'b0, 32'd2); send(1'b0, 32'd2); send(1'b1, ADD); send(1'b1, EOE);
    wait_done();

    // Full stack is legal, one more push overflows
    expect_val(32'd10);
    send(1'b0, 32'd1); send(1'b0, 32'd2); send(1'b0, 32'd3); send(1'b0, 32'd4);
    send(1'b1, ADD); send(1'b1, ADD); send(1'b1, ADD); send(1'b1, EOE);
    wait_done();
    expect_err(2);
    for (int i = 1; i <= 5; i++) send(1'b0, WIDTH'(i));
    send(1'b1, EOE);
    wait_done();
    expect_err(4);
    send(1'b0, 32'd1); send(1'b0, 32'd2); send(1'b1, EOE);
    wait_done();
    expect_err(4);
    send(1'b1, EOE);
    wait_done();
    expect_err(3);
    send(1'b0, 32'd9); send(1'b1, 32'd6); send(1'b0, 32'd1); send(1'b1, EOE);
    wait_done();

    // Backpressure: result held 10 cycles, pending token not acked
    hold = 1'b1;
    expect_val(32'd6);
    expect_val(32'd1);
    send(1'b0, 32'd6); send(1'b1, EOE);
    wait_res_stb();
    fork
      send(1'b0, 32'd1);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("hold_res_stb", EW'(res_stb), EW'(1));
          check("hold_res_dat", {res_err, res_dat}, {1'b0, 32'd6});
          check("hold_tok_ack", EW'(tok_ack), EW'(0));
        end
        hold = 1'b0;
      end
    join
    send(1'b1, EOE);
    wait_done();

    // Reset while in EXEC with a stale entry below: stack must come back empty
    send(1'b0, 32'd7); send(1'b0, 32'd1); send(1'b0, 32'd2); send(1'b1, ADD);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_exec_tok_ack", EW'(tok_ack), EW'(0));
    check("rst_exec_res_stb", EW'(res_stb), EW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_val(32'd8);
    send(1'b0, 32'd8); send(1'b1, EOE);
    wait_done();

    // Reset while an error result is presented clears outputs at once
    hold = 1'b1;
    send(1'b1, EOE);
    wait_res_stb();
    check("pre_rst_res", {res_err, res_dat}, {1'b1, 32'd4});
    #1 rst = 1'b1;
    #1;
    check("rst_res_stb", EW'(res_stb), EW'(0));
    check("rst_res_dat_async", EW'(res_dat), EW'(0));
    check("rst_res_err_async", EW'(res_err), EW'(0));
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    expect_val(32'd8);
    send(1'b0, 32'd8); send(1'b1, EOE);
    wait_done();

    repeat (3) @(negedge clk);
    check("no_spurious_res", EW'(res_stb), EW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
